// File: rtl/vga_native_regfile.sv
// VGA control register file: staged registers written over the native bus,
// committed to the display outputs on the first frame_start_i after a COMMIT.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   write_en_i, addr_write_i native write strobe and word address
//   data_i                   native write data
//   read_en_i, addr_read_i   native read strobe and word address
//   data_o                   registered read data (1-cycle latency)
//   frame_start_i            first-pixel-of-frame pulse
//   enable_o, h_active_o,
//   v_active_o, bg_color_o   committed display configuration
//   update_pending_o         staged values await next frame_start_i
//
// The STATUS word places the frame counter in bits [31:16], so DATA_WIDTH
// is expected to be at least 32.
module vga_native_regfile #(
   parameter int DATA_WIDTH        = 32,
   parameter int NATIVE_ADDR_WIDTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         write_en_i,
   input  logic [NATIVE_ADDR_WIDTH-1:0] addr_write_i,
   input  logic [DATA_WIDTH-1:0]        data_i,
   input  logic                         read_en_i,
   input  logic [NATIVE_ADDR_WIDTH-1:0] addr_read_i,
   output logic [DATA_WIDTH-1:0]        data_o,
   input  logic                         frame_start_i,
   output logic                         enable_o,
   output logic [11:0]                  h_active_o,
   output logic [11:0]                  v_active_o,
   output logic [11:0]                  bg_color_o,
   output logic                         update_pending_o
);

   localparam logic [NATIVE_ADDR_WIDTH-1:0] A_CTRL    = NATIVE_ADDR_WIDTH'(0);
   localparam logic [NATIVE_ADDR_WIDTH-1:0] A_H       = NATIVE_ADDR_WIDTH'(1);
   localparam logic [NATIVE_ADDR_WIDTH-1:0] A_V       = NATIVE_ADDR_WIDTH'(2);
   localparam logic [NATIVE_ADDR_WIDTH-1:0] A_BG      = NATIVE_ADDR_WIDTH'(3);
   localparam logic [NATIVE_ADDR_WIDTH-1:0] A_STATUS  = NATIVE_ADDR_WIDTH'(4);
   localparam logic [NATIVE_ADDR_WIDTH-1:0] A_SCRATCH = NATIVE_ADDR_WIDTH'(5);

   localparam logic [11:0] H_RST = 12'h280;
   localparam logic [11:0] V_RST = 12'h1E0;

   logic                  stg_en;
   logic [11:0]           stg_h;
   logic [11:0]           stg_v;
   logic [11:0]           stg_bg;
   logic [DATA_WIDTH-1:0] scratch;
   logic                  pending;
   logic [15:0]           fcnt;
   logic [DATA_WIDTH-1:0] rd_next;
   logic                  commit_wr;
   logic                  apply;

   assign commit_wr = write_en_i && (addr_write_i == A_CTRL) && data_i[1];
   // A COMMIT coinciding with frame_start_i defers the copy to the next frame.
   assign apply = frame_start_i && pending && !commit_wr;

   assign update_pending_o = pending;

   // Read mux sees pre-write state, so same-cycle read/write returns old data.
   always_comb begin
      rd_next = '0;
      case (addr_read_i)
         A_CTRL:    rd_next[0]     = stg_en;
         A_H:       rd_next[11:0]  = stg_h;
         A_V:       rd_next[11:0]  = stg_v;
         A_BG:      rd_next[11:0]  = stg_bg;
         A_STATUS: begin
            rd_next[0]     = pending;
            rd_next[31:16] = fcnt;
         end
         A_SCRATCH: rd_next        = scratch;
         default:   rd_next        = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stg_en     <= 1'b0;
         stg_h      <= H_RST;
         stg_v      <= V_RST;
         stg_bg     <= 12'h000;
         scratch    <= '0;
         pending    <= 1'b0;
         fcnt       <= 16'h0000;
         enable_o   <= 1'b0;
         h_active_o <= H_RST;
         v_active_o <= V_RST;
         bg_color_o <= 12'h000;
         data_o     <= '0;
      end else begin
         if (frame_start_i) begin
            fcnt <= fcnt + 16'd1;
         end

         if (apply) begin
            enable_o   <= stg_en;
            h_active_o <= stg_h;
            v_active_o <= stg_v;
            bg_color_o <= stg_bg;
         end

         if (commit_wr) begin
            pending <= 1'b1;
         end else if (frame_start_i) begin
            pending <= 1'b0;
         end

         if (write_en_i) begin
            case (addr_write_i)
               A_CTRL:    stg_en  <= data_i[0];
               A_H:       stg_h   <= data_i[11:0];
               A_V:       stg_v   <= data_i[11:0];
               A_BG:      stg_bg  <= data_i[11:0];
               A_SCRATCH: scratch <= data_i;
               default:   ;
            endcase
         end

         if (read_en_i) begin
            data_o <= rd_next;
         end
      end
   end

endmodule

// File: tb/tb_vga_native_regfile.sv
// Self-checking bench for vga_native_regfile: directed scenarios followed by
// random traffic, all checked against an array-based reference model.
module tb_vga_native_regfile;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        write_en_i = 1'b0;
   logic [7:0]  addr_write_i = '0;
   logic [31:0] data_i = '0;
   logic        read_en_i = 1'b0;
   logic [7:0]  addr_read_i = '0;
   logic [31:0] data_o;
   logic        frame_start_i = 1'b0;
   logic        enable_o;
   logic [11:0] h_active_o;
   logic [11:0] v_active_o;
   logic [11:0] bg_color_o;
   logic        update_pending_o;

   int total = 0;
   int bad = 0;

   // reference model: staged words by address, committed words, flags
   logic [31:0] m_stg [0:5];
   logic [31:0] m_com [0:3];
   logic        m_pend;
   int          m_fcnt;
   logic [31:0] m_rd;

   vga_native_regfile #(
      .DATA_WIDTH(32),
      .NATIVE_ADDR_WIDTH(8)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .write_en_i(write_en_i),
      .addr_write_i(addr_write_i),
      .data_i(data_i),
      .read_en_i(read_en_i),
      .addr_read_i(addr_read_i),
      .data_o(data_o),
      .frame_start_i(frame_start_i),
      .enable_o(enable_o),
      .h_active_o(h_active_o),
      .v_active_o(v_active_o),
      .bg_color_o(bg_color_o),
      .update_pending_o(update_pending_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_mask(input int a);
      case (a)
         0:       return 32'h1;
         1, 2, 3: return 32'hFFF;
         5:       return 32'hFFFF_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input int a);
      if (a == 4) return ((m_fcnt & 32'hFFFF) << 16) | 32'(m_pend);
      if (a > 5) return 32'h0;
      return m_stg[a];
   endfunction

   task automatic m_reset();
      m_stg[0] = 0; m_stg[1] = 32'h280; m_stg[2] = 32'h1E0;
      m_stg[3] = 0; m_stg[4] = 0;       m_stg[5] = 0;
      for (int i = 0; i < 4; i++) m_com[i] = m_stg[i];
      m_pend = 1'b0;
      m_fcnt = 0;
      m_rd = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".data"}, data_o, m_rd);
      chk({tag, ".en"}, 32'(enable_o), m_com[0]);
      chk({tag, ".h"}, 32'(h_active_o), m_com[1]);
      chk({tag, ".v"}, 32'(v_active_o), m_com[2]);
      chk({tag, ".bg"}, 32'(bg_color_o), m_com[3]);
      chk({tag, ".pend"}, 32'(update_pending_o), 32'(m_pend));
   endtask

   // One clock: drive inputs, advance the model, check one step after edge.
   task automatic step(input string tag, input logic r, input logic we,
                       input int wa, input logic [31:0] wd,
                       input logic re, input int ra, input logic fs);
      logic commit;
      rst_i = r; write_en_i = we; addr_write_i = 8'(wa); data_i = wd;
      read_en_i = re; addr_read_i = 8'(ra); frame_start_i = fs;
      @(posedge clk);
      #1;
      if (r) begin
         m_reset();
      end else begin
         commit = we && wa == 0 && wd[1];
         if (re) m_rd = m_read(ra);
         if (fs && m_pend && !commit)
            for (int i = 0; i < 4; i++) m_com[i] = m_stg[i];
         if (fs) m_fcnt = (m_fcnt + 1) % 65536;
         if (commit) m_pend = 1'b1;
         else if (fs) m_pend = 1'b0;
         if (we && wa <= 5 && wa != 4) m_stg[wa] = wd & m_mask(wa);
      end
      rst_i = 0; write_en_i = 0; read_en_i = 0; frame_start_i = 0;
      chk_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input string tag, input int a, input logic [31:0] d);
      step(tag, 0, 1, a, d, 0, 0, 0);
   endtask

   task automatic rd(input string tag, input int a);
      step(tag, 0, 0, 0, 0, 1, a, 0);
   endtask

   task automatic fs(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      m_reset();
      step("rst", 1, 1, 0, 32'h3, 1, 1, 1);
      chk("rst.h_const", 32'(h_active_o), 32'h280);
      chk("rst.v_const", 32'(v_active_o), 32'h1E0);

      // reset values of words 0..5
      rd("r0", 0); chk("r0c", data_o, 32'h0);
      rd("r1", 1); chk("r1c", data_o, 32'h280);
      rd("r2", 2); chk("r2c", data_o, 32'h1E0);
      rd("r3", 3); chk("r3c", data_o, 32'h0);
      rd("r4", 4); chk("r4c", data_o, 32'h0);
      rd("r5", 5); chk("r5c", data_o, 32'h0);

      // staged write + commit + frame start
      wr("w_h", 1, 32'hFFFF_F320);
      wr("w_bg", 3, 32'h0000_0F0F);
      wr("w_ctrl", 0, 32'h3);
      idle("hold");
      chk("pre.h", 32'(h_active_o), 32'h280);
      fs("fs1");
      chk("c.h", 32'(h_active_o), 32'h320);
      chk("c.bg", 32'(bg_color_o), 32'hF0F);
      chk("c.en", 32'(enable_o), 32'h1);
      chk("c.pend", 32'(update_pending_o), 32'h0);
      rd("st", 4); chk("st.b0", data_o & 32'h1, 32'h0);
      rd("ctrl", 0); chk("ctrl.rd", data_o, 32'h1);

      // staged write without commit
      step("rst2", 1, 0, 0, 0, 0, 0, 0);
      wr("w_v", 2, 32'h258);
      fs("fsa"); fs("fsb");
      chk("nc.v", 32'(v_active_o), 32'h1E0);
      rd("st2", 4); chk("st2c", data_o, 32'h0002_0000);

      // commit coincident with frame start
      step("cfs", 0, 1, 0, 32'h2, 0, 0, 1);
      chk("cfs.v", 32'(v_active_o), 32'h1E0);
      chk("cfs.pend", 32'(update_pending_o), 32'h1);
      fs("cfs2");
      chk("cfs2.v", 32'(v_active_o), 32'h258);
      chk("cfs2.pend", 32'(update_pending_o), 32'h0);

      // scratch, unmapped, read-only status
      step("sc", 0, 1, 5, 32'hDEAD_BEEF, 1, 5, 0);
      chk("sc.old", data_o, 32'h0);
      rd("sc2", 5); chk("sc2c", data_o, 32'hDEAD_BEEF);
      rd("un7", 7); chk("un7c", data_o, 32'h0);
      wr("wst", 4, 32'hFFFF_FFFF);
      rd("st3", 4); chk("st3c", data_o, 32'h0004_0000);
      wr("wun", 9, 32'h1234_5678);
      rd("un9", 9);

      // frame counter wrap
      step("rst3", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65536; i++) fs("wrap");
      rd("st4", 4); chk("st4.cnt", data_o >> 16, 32'h0);

      // reset discards pending
      wr("w_h2", 1, 32'h111);
      wr("w_c2", 0, 32'h3);
      chk("p.set", 32'(update_pending_o), 32'h1);
      step("rst4", 1, 1, 0, 32'h3, 1, 4, 1);
      chk("rst4.pend", 32'(update_pending_o), 32'h0);
      chk("rst4.h", 32'(h_active_o), 32'h280);
      fs("after");
      chk("after.h", 32'(h_active_o), 32'h280);
      chk("after.en", 32'(enable_o), 32'h0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic r, we, re, f;
         int wa, ra;
         logic [31:0] wd;
         r  = ($urandom_range(0, 99) == 0);
         we = ($urandom_range(0, 1) == 1);
         re = ($urandom_range(0, 2) != 0);
         f  = ($urandom_range(0, 5) == 0);
         wa = (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7));
         ra = $urandom_range(0, 7);
         wd = $urandom;
         step("rnd", r, we, wa, wd, re, ra, f);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
